// File: rtl/flash_pkg.sv
// Shared definitions for the boot-time flash block loader and the CPU SPI port decoder.
// Holds the loader state encoding, the flash read opcode and the SPI port register numbers.
package flash_pkg;

    // Flash opcode for a plain (non-fast) sequential read
    localparam logic [7:0] FLASH_READ_CMD = 8'h03;

    // Byte shifted out while clocking data in from the flash
    localparam logic [7:0] SPI_DUMMY_TX = 8'hFF;

    // CPU-visible SPI port and chip-select register numbers
    localparam logic [7:0] SPIPORT = 8'h02;
    localparam logic [7:0] CSPIN   = 8'h03;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_A2,
        S_A1,
        S_A0,
        S_RD,
        S_WR,
        S_HOLD,
        S_FIN
    } ldr_state_e;

endpackage

// File: rtl/loader_gap_counter.sv
// Chip-select gap timer for the flash block loader.
// Ports: clk, rst (sync, active-high); run_i counts down while high and reloads
// preset_i while low; zero_o flags that the count has reached zero.
module loader_gap_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run_i,
    input  logic [W-1:0] preset_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = preset_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= preset_i;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flash_block_loader.sv
// Boot loader sequencer: drives the byte-level SPI engine to copy a block of SPI
// flash into SRAM without CPU help, using a READ command and a 24-bit address.
// Ports: start/abort/flash_addr/mem_base/length control a transfer; busy, done,
// aborted report status; owner, flash_cs_n, sd_cs_force_n claim the SPI bus;
// spi_start/spi_tx/spi_done/spi_rx talk to the engine; mem_req/mem_addr/
// mem_data/mem_ack write each received byte into SRAM.
module flash_block_loader
    import flash_pkg::*;
#(
    parameter logic [7:0]  READ_CMD = FLASH_READ_CMD,
    parameter int unsigned MEM_AW   = 21,
    parameter int unsigned CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [23:0]       flash_addr,
    input  logic [MEM_AW-1:0] mem_base,
    input  logic [15:0]       length,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              owner,
    output logic              flash_cs_n,
    output logic              sd_cs_force_n,
    output logic              spi_start,
    output logic [7:0]        spi_tx,
    input  logic              spi_done,
    input  logic [7:0]        spi_rx,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ack
);

    // Counter holds CS_GAP-1 so that SETUP and HOLD each last CS_GAP cycles
    localparam int unsigned GW = (CS_GAP < 3) ? 1 : $clog2(CS_GAP);
    localparam logic [GW-1:0] GAP_PRESET = GW'(CS_GAP - 1);

    ldr_state_e        state_q,     state_d;
    logic [23:0]       addr_q,      addr_d;
    logic [15:0]       remain_q,    remain_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              aborted_q,   aborted_d;
    logic              owner_q,     owner_d;
    logic              cs_n_q,      cs_n_d;
    logic              spi_start_q, spi_start_d;
    logic [7:0]        spi_tx_q,    spi_tx_d;
    logic              mem_req_q,   mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_data_q,  mem_data_d;

    logic gap_run;
    logic gap_zero;

    // The counter reloads in every other state, so it is already preset on entry
    assign gap_run = (state_q == S_SETUP) || (state_q == S_HOLD);

    loader_gap_counter #(
        .W (GW)
    ) u_gap (
        .clk      (clk),
        .rst      (rst),
        .run_i    (gap_run),
        .preset_i (GAP_PRESET),
        .zero_o   (gap_zero)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        owner_d     = owner_q;
        cs_n_d      = cs_n_q;
        spi_start_d = 1'b0;
        spi_tx_d    = spi_tx_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = flash_addr;
                    remain_d   = length;
                    mem_addr_d = mem_base;
                    aborted_d  = 1'b0;
                    busy_d     = 1'b1;
                    if (length == 16'd0) begin
                        state_d = S_FIN;
                    end else begin
                        owner_d = 1'b1;
                        cs_n_d  = 1'b0;
                        state_d = S_SETUP;
                    end
                end
            end

            S_SETUP: begin
                if (gap_zero) begin
                    spi_start_d = 1'b1;
                    spi_tx_d    = READ_CMD;
                    state_d     = S_CMD;
                end
            end

            S_CMD, S_A2, S_A1, S_A0: begin
                if (spi_done) begin
                    if (abort) begin
                        // Header byte has finished; stop before the next one
                        aborted_d = 1'b1;
                        cs_n_d    = 1'b1;
                        spi_tx_d  = SPI_DUMMY_TX;
                        state_d   = S_HOLD;
                    end else begin
                        spi_start_d = 1'b1;
                        unique case (state_q)
                            S_CMD: begin
                                spi_tx_d = addr_q[23:16];
                                state_d  = S_A2;
                            end
                            S_A2: begin
                                spi_tx_d = addr_q[15:8];
                                state_d  = S_A1;
                            end
                            S_A1: begin
                                spi_tx_d = addr_q[7:0];
                                state_d  = S_A0;
                            end
                            default: begin
                                spi_tx_d = SPI_DUMMY_TX;
                                state_d  = S_RD;
                            end
                        endcase
                    end
                end
            end

            S_RD: begin
                if (spi_done) begin
                    mem_data_d = spi_rx;
                    mem_req_d  = 1'b1;
                    state_d    = S_WR;
                end
            end

            S_WR: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    mem_addr_d = mem_addr_q + MEM_AW'(1);
                    remain_d   = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        cs_n_d  = 1'b1;
                        state_d = S_HOLD;
                    end else if (abort) begin
                        aborted_d = 1'b1;
                        cs_n_d    = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        // Next byte starts only after the SRAM took this one
                        spi_start_d = 1'b1;
                        state_d     = S_RD;
                    end
                end
            end

            S_HOLD: begin
                if (gap_zero) begin
                    owner_d = 1'b0;
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            owner_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_tx_q    <= SPI_DUMMY_TX;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            owner_q     <= owner_d;
            cs_n_q      <= cs_n_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign owner      = owner_q;
    assign flash_cs_n = cs_n_q;
    assign spi_start  = spi_start_q;
    assign spi_tx     = spi_tx_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;

    // SD card is never selected by this block; the forced-high level is what
    // the SD chip-select logic sees whenever the loader owns the bus
    assign sd_cs_force_n = 1'b1;

endmodule

// File: doc/flash_block_loader.md
Name: flash_block_loader

Overview:
- Hardware sequencer that drives the shared byte-level SPI engine to copy a block of SPI flash into SRAM without CPU involvement. Used at boot to load ROM images.
- Sits between the SPI engine and the flash/SD chip-select logic. While active, it owns the engine, forces the SD CS high and holds off CPU SPI port accesses.
- Issues READ command 0x03, sends a 24-bit address, streams LEN bytes, and writes each byte to SRAM through a request/acknowledge port.

Parameters:
- READ_CMD, 8'h03, flash read opcode sent first.
- MEM_AW, 21, SRAM address width.
- CS_GAP, 2, idle cycles with CS low before the first byte and with CS high after the last byte (minimum 1).

Ports:
- clk  in  1  system clock (7 MHz)
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a transfer when idle
- abort  in  1  level; requests early termination
- flash_addr  in  24  first flash byte address, sampled on start
- mem_base  in  MEM_AW  first SRAM address, sampled on start
- length  in  16  byte count, sampled on start; 0 is legal
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- aborted  out  1  status of last transfer; valid with done, held until next start
- owner  out  1  high while loader owns the SPI engine and CS lines (CPU port accesses gated off)
- flash_cs_n  out  1  flash chip select, active-low
- sd_cs_force_n  out  1  held high (SD deselected) while owner
- spi_start  out  1  one-cycle pulse to engine; spi_tx valid the same cycle
- spi_tx  out  8  byte to transmit (8'hFF during data phase)
- spi_done  in  1  one-cycle pulse from engine; spi_rx valid the same cycle
- spi_rx  in  8  received byte
- mem_req  out  1  SRAM write request; held with mem_addr/mem_data until mem_ack
- mem_addr  out  MEM_AW  SRAM write address
- mem_data  out  8  SRAM write data
- mem_ack  in  1  write accepted (one cycle)

Behaviour:
- Reset values: busy=0, done=0, aborted=0, owner=0, flash_cs_n=1, sd_cs_force_n=1, spi_start=0, spi_tx=8'hFF, mem_req=0, mem_addr=0, mem_data=0. Reset mid-transfer deasserts flash_cs_n on the next edge and drops the in-flight byte; any late spi_done is ignored.
- States: IDLE, SETUP, CMD, A2, A1, A0, RD, WR, HOLD, FIN.
- IDLE:
  - A start pulse latches flash_addr, mem_base and length, and clears aborted.
  - length==0 goes to FIN: done pulses 2 cycles after start, flash_cs_n never asserted.
  - Otherwise busy=1, owner=1, flash_cs_n=0, go to SETUP.
  - start while busy is ignored.
- SETUP: wait CS_GAP cycles, then go to CMD.
- CMD/A2/A1/A0:
  - Pulse spi_start with READ_CMD, addr[23:16], addr[15:8], addr[7:0] in turn.
  - Wait for spi_done before advancing; exactly one spi_start per byte.
- RD:
  - Pulse spi_start with tx=8'hFF.
  - On spi_done, capture spi_rx into mem_data, raise mem_req, go to WR.
- WR:
  - Hold mem_req until mem_ack.
  - On ack: mem_addr+1 (wraps modulo 2^MEM_AW), remaining count-1.
  - If count reaches 0, or abort is sampled high, go to HOLD; else go to RD.
  - The next spi_start is issued no earlier than the cycle after mem_ack.
- Abort:
  - Sampled only at byte boundaries (the WR ack cycle, or the spi_done cycle in CMD/A*).
  - The in-flight SPI byte always completes.
  - Sets aborted=1 and goes to HOLD.
- HOLD: flash_cs_n=1 immediately, wait CS_GAP cycles, owner=0, go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- The flash address is not incremented by the loader; the flash auto-increments. Crossing the top of flash is the flash's wraparound behaviour.
- Throughput: one byte per (engine time + 2 + memory latency) cycles.

Decomposition:
- Shared package flash_pkg:
  - State encoding typedef.
  - READ_CMD and the SPI/ZX-Uno port and register constants (SPIPORT 8'h02, CSPIN 8'h03), shared with the CPU-port decoder.
- Sub-module loader_gap_counter: small down-counter used by SETUP and HOLD. Everything else stays inline.

Test Plan:
- start with flash_addr=24'h012345, length=4, mem_base=0, engine model returning AA,BB,CC,DD:
  - spi_tx sequence 03,01,23,45,FF×4.
  - SRAM writes 0:AA, 1:BB, 2:CC, 3:DD.
  - One done pulse, aborted=0, flash_cs_n low only between SETUP and HOLD.
- length=0: done 2 cycles after start, no spi_start, flash_cs_n stays 1, owner stays 0.
- mem_base=21'h1FFFFE, length=4: writes land at 1FFFFE, 1FFFFF, 000000, 000001.
- abort raised during the 2nd data byte of length=10:
  - That byte completes and is written.
  - Exactly 2 SRAM writes, CS released, done with aborted=1.
- mem_ack delayed 5 cycles per write: mem_req/mem_addr/mem_data stable throughout; no spi_start until the cycle after ack.
- rst asserted mid-RD: next cycle flash_cs_n=1, busy=0, owner=0; a following start runs a clean full transfer.
